// File: rtl/fpu_addsub_pipe.sv
// fpu_addsub_pipe: three-stage pipelined IEEE-style floating-point adder/subtractor.
//   S1 unpacks, sorts operands by magnitude and aligns the smaller one (guard/round/sticky).
//   S2 adds or subtracts significands and counts leading zeros.
//   S3 normalizes, rounds to nearest-even, packs, and drives the registered outputs.
// Ports:
//   clock, reset_n            - single rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready         - operation handshake; in_ready never looks at in_valid
//   sub, a, b, in_tag         - a+b (sub=0) or a-b (sub=1), operands packed {sign, exp, frac}
//   out_valid/out_ready       - result handshake; outputs hold while stalled
//   result, out_tag           - rounded result and the tag that travelled with it
//   condCodes                 - {Z, C, N, V}
//   opStatusFlags             - {OF, UF, NX, NV}
module fpu_addsub_pipe #(
  parameter int unsigned EXPW  = 5,
  parameter int unsigned FRACW = 10,
  parameter int unsigned TAGW  = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sub,
  input  logic [EXPW+FRACW:0] a,
  input  logic [EXPW+FRACW:0] b,
  input  logic [TAGW-1:0]     in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [EXPW+FRACW:0] result,
  output logic [TAGW-1:0]     out_tag,
  output logic [3:0]          condCodes,
  output logic [3:0]          opStatusFlags
);

  localparam int unsigned W        = EXPW + FRACW + 1;
  localparam int unsigned MW       = FRACW + 1;  // significand incl. hidden bit
  localparam int unsigned MaxShift = FRACW + 3;  // significand + guard + round
  localparam int unsigned AW       = FRACW + 4;  // significand + guard + round + sticky
  localparam int unsigned SW       = FRACW + 5;  // plus carry-out
  localparam int unsigned XW       = EXPW + 2;   // exponent headroom for carry and round-up
  localparam int unsigned LW       = $clog2(SW + 1);

  localparam logic [EXPW-1:0] ExpOnes = '1;
  localparam logic [W-1:0]    QNaN    = {1'b0, ExpOnes, 1'b1, {(FRACW-1){1'b0}}};

  // ---------------------------------------------------------------------------------------------
  // Handshake: a stage loads when it is empty or its contents move on this cycle.
  // ---------------------------------------------------------------------------------------------
  logic s1ValidQ, s2ValidQ;
  logic s1Ready, s2Ready, s3Ready;

  assign s3Ready  = !out_valid || out_ready;
  assign s2Ready  = !s2ValidQ || s3Ready;
  assign s1Ready  = !s1ValidQ || s2Ready;
  assign in_ready = s1Ready;

  // ---------------------------------------------------------------------------------------------
  // S1: unpack, classify, sort, align
  // ---------------------------------------------------------------------------------------------
  logic            signA, signB;
  logic [EXPW-1:0] expA, expB;
  logic [FRACW-1:0] fracA, fracB;
  logic            nanA, nanB, infA, infB, zeroA, zeroB;
  logic            infClash, s1Nan, s1Nv, s1Inf, s1InfSign, s1NegZero;
  logic            swap, signL, signS;
  logic [EXPW-1:0] expL, expS, expLEff, expSEff;
  logic [FRACW-1:0] fracL, fracS;
  logic [MW-1:0]   mantL, mantS;
  logic [31:0]     shiftRaw, shiftSat;
  logic [2*MaxShift-1:0] alignWide;
  logic [AW-1:0]   s1MantL, s1MantS;

  assign signA = a[W-1];
  assign expA  = a[W-2:FRACW];
  assign fracA = a[FRACW-1:0];
  assign signB = b[W-1] ^ sub;  // effective sign of the second operand
  assign expB  = b[W-2:FRACW];
  assign fracB = b[FRACW-1:0];

  assign nanA  = (expA == ExpOnes) && (fracA != '0);
  assign nanB  = (expB == ExpOnes) && (fracB != '0);
  assign infA  = (expA == ExpOnes) && (fracA == '0);
  assign infB  = (expB == ExpOnes) && (fracB == '0);
  assign zeroA = (a[W-2:0] == '0);
  assign zeroB = (b[W-2:0] == '0);

  assign infClash  = infA && infB && (signA != signB);
  assign s1Nan     = nanA || nanB || infClash;
  // Signalling NaN (quiet bit clear) or inf-inf raises invalid.
  assign s1Nv      = (nanA && !fracA[FRACW-1]) || (nanB && !fracB[FRACW-1]) || infClash;
  assign s1Inf     = (infA || infB) && !s1Nan;
  assign s1InfSign = infA ? signA : signB;
  assign s1NegZero = zeroA && zeroB && signA && signB;

  // Packed {exp, frac} orders the same way as the magnitude.
  assign swap  = b[W-2:0] > a[W-2:0];
  assign signL = swap ? signB : signA;
  assign signS = swap ? signA : signB;
  assign expL  = swap ? expB : expA;
  assign expS  = swap ? expA : expB;
  assign fracL = swap ? fracB : fracA;
  assign fracS = swap ? fracA : fracB;

  assign expLEff = (expL == '0) ? EXPW'(1) : expL;
  assign expSEff = (expS == '0) ? EXPW'(1) : expS;
  assign mantL   = {expL != '0, fracL};
  assign mantS   = {expS != '0, fracS};

  assign shiftRaw = 32'(expLEff) - 32'(expSEff);
  assign shiftSat = (shiftRaw > 32'(MaxShift)) ? 32'(MaxShift) : shiftRaw;

  // Low half collects every bit pushed beyond the round position.
  assign alignWide = {mantS, 2'b00, {MaxShift{1'b0}}} >> shiftSat;
  assign s1MantS   = {alignWide[2*MaxShift-1:MaxShift], |alignWide[MaxShift-1:0]};
  assign s1MantL   = {mantL, 3'b000};

  logic            s1NanQ, s1NvQ, s1InfQ, s1InfSignQ, s1NegZeroQ, s1SignQ, s1EffSubQ;
  logic [EXPW-1:0] s1ExpQ;
  logic [AW-1:0]   s1MantLQ, s1MantSQ;
  logic [TAGW-1:0] s1TagQ;

  // ---------------------------------------------------------------------------------------------
  // S2: significand add/sub and leading-zero count
  // ---------------------------------------------------------------------------------------------
  logic [SW-1:0] s2Sum;
  logic [LW-1:0] s2Lzc;

  // Operands are sorted, so the difference is never negative.
  assign s2Sum = s1EffSubQ ? ({1'b0, s1MantLQ} - {1'b0, s1MantSQ})
                           : ({1'b0, s1MantLQ} + {1'b0, s1MantSQ});

  always_comb begin
    s2Lzc = LW'(AW);
    for (int i = 0; i < int'(AW); i++) begin
      if (s2Sum[i]) s2Lzc = LW'(int'(AW) - 1 - i);
    end
  end

  logic            s2NanQ, s2NvQ, s2InfQ, s2InfSignQ, s2NegZeroQ, s2SignQ;
  logic [EXPW-1:0] s2ExpQ;
  logic [SW-1:0]   s2SumQ;
  logic [LW-1:0]   s2LzcQ;
  logic [TAGW-1:0] s2TagQ;

  // ---------------------------------------------------------------------------------------------
  // S3: normalize, round, pack
  // ---------------------------------------------------------------------------------------------
  logic [31:0]     lzWide, expRoom, lShift;
  logic [AW-1:0]   norm;
  logic [XW-1:0]   expN, expOut;
  logic [MW-1:0]   keep;
  logic [MW:0]     rounded;
  logic [FRACW-1:0] fracOut;
  logic            roundUp, nx, tiny, ovf, sumZero;
  logic [W-1:0]    resD;
  logic [3:0]      flagsD, ccD;

  assign lzWide  = 32'(s2LzcQ);
  assign expRoom = 32'(s2ExpQ) - 32'd1;  // left shifts stop at the subnormal exponent
  assign lShift  = (lzWide < expRoom) ? lzWide : expRoom;

  always_comb begin
    if (s2SumQ[SW-1]) begin
      norm = {s2SumQ[SW-1:2], s2SumQ[1] | s2SumQ[0]};
      expN = XW'(s2ExpQ) + XW'(1);
    end else begin
      norm = s2SumQ[AW-1:0] << lShift;
      expN = XW'(32'(s2ExpQ) - lShift);
    end
  end

  assign keep    = norm[AW-1:3];
  assign nx      = |norm[2:0];
  assign roundUp = norm[2] && (norm[1] || norm[0] || keep[0]);
  assign rounded = {1'b0, keep} + {{MW{1'b0}}, roundUp};
  assign tiny    = !norm[AW-1];
  assign sumZero = (s2SumQ == '0);

  always_comb begin
    if (rounded[MW]) begin
      expOut  = expN + XW'(1);
      fracOut = rounded[FRACW:1];
    end else if (rounded[MW-1]) begin
      expOut  = expN;
      fracOut = rounded[FRACW-1:0];
    end else begin
      expOut  = '0;
      fracOut = rounded[FRACW-1:0];
    end
  end

  assign ovf = expOut >= XW'(ExpOnes);

  always_comb begin
    resD   = '0;
    flagsD = '0;
    if (s2NanQ) begin
      resD   = QNaN;
      flagsD = {3'b000, s2NvQ};
    end else if (s2InfQ) begin
      resD   = {s2InfSignQ, ExpOnes, {FRACW{1'b0}}};
    end else if (sumZero) begin
      resD   = {s2NegZeroQ, {(W-1){1'b0}}};
    end else if (ovf) begin
      resD   = {s2SignQ, ExpOnes, {FRACW{1'b0}}};
      flagsD = 4'b1010;
    end else begin
      resD   = {s2SignQ, expOut[EXPW-1:0], fracOut};
      flagsD = {1'b0, tiny && nx, nx, 1'b0};
    end
  end

  assign ccD = {resD[W-2:0] == '0, 1'b0, resD[W-1], flagsD[3]};

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1ValidQ      <= 1'b0;
      s2ValidQ      <= 1'b0;
      out_valid     <= 1'b0;
      result        <= '0;
      out_tag       <= '0;
      condCodes     <= '0;
      opStatusFlags <= '0;
    end else begin
      if (s1Ready) s1ValidQ <= in_valid;
      if (s2Ready) s2ValidQ <= s1ValidQ;
      if (s3Ready) begin
        out_valid <= s2ValidQ;
        if (s2ValidQ) begin
          result        <= resD;
          out_tag       <= s2TagQ;
          condCodes     <= ccD;
          opStatusFlags <= flagsD;
        end
      end
    end
  end

  // Datapath registers need no reset; the valid bits decide what is visible.
  always_ff @(posedge clock) begin
    if (s1Ready && in_valid) begin
      s1NanQ     <= s1Nan;
      s1NvQ      <= s1Nv;
      s1InfQ     <= s1Inf;
      s1InfSignQ <= s1InfSign;
      s1NegZeroQ <= s1NegZero;
      s1SignQ    <= signL;
      s1EffSubQ  <= signL ^ signS;
      s1ExpQ     <= expLEff;
      s1MantLQ   <= s1MantL;
      s1MantSQ   <= s1MantS;
      s1TagQ     <= in_tag;
    end
    if (s2Ready && s1ValidQ) begin
      s2NanQ     <= s1NanQ;
      s2NvQ      <= s1NvQ;
      s2InfQ     <= s1InfQ;
      s2InfSignQ <= s1InfSignQ;
      s2NegZeroQ <= s1NegZeroQ;
      s2SignQ    <= s1SignQ;
      s2ExpQ     <= s1ExpQ;
      s2SumQ     <= s2Sum;
      s2LzcQ     <= s2Lzc;
      s2TagQ     <= s1TagQ;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Directed bench for fpu_addsub_pipe at default widths (half precision).
module tb_fpu_addsub_pipe;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  out_tag;
  logic [3:0]  condCodes;
  logic [3:0]  opStatusFlags;

  int checks   = 0;
  int failures = 0;

  logic [19:0] seen[$];  // {tag, result} of every consumed output

  fpu_addsub_pipe #(
    .EXPW (5),
    .FRACW(10),
    .TAGW (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sub          (sub),
    .a            (a),
    .b            (b),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .out_tag      (out_tag),
    .condCodes    (condCodes),
    .opStatusFlags(opStatusFlags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset_n && out_valid && out_ready) seen.push_back({out_tag, result});
  end

  task automatic checkEq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic doOp(input string name, input logic [15:0] va, input logic [15:0] vb,
                      input logic vs, input logic [3:0] vt, input logic [15:0] expRes,
                      input logic [3:0] expCc, input logic [3:0] expFl);
    int lat;
    a        = va;
    b        = vb;
    sub      = vs;
    in_tag   = vt;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clock); #1;
      lat++;
    end
    checkEq({name, "_lat"}, lat, 3);
    checkEq({name, "_res"}, result, expRes);
    checkEq({name, "_tag"}, out_tag, vt);
    checkEq({name, "_cc"}, condCodes, expCc);
    checkEq({name, "_flags"}, opStatusFlags, expFl);
    @(posedge clock); #1;
  endtask

  logic [15:0] burstB   [5] = '{16'h3C00, 16'h4000, 16'h4400, 16'h4800, 16'h4C00};
  logic [15:0] burstExp [5] = '{16'h4000, 16'h4200, 16'h4500, 16'h4880, 16'h4C40};

  initial begin
    int idx, stallLeft, cnt;
    logic stalled, sawFull, acc;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sub       = 1'b0;
    a         = '0;
    b         = '0;
    in_tag    = '0;
    @(posedge clock); @(posedge clock); #1;
    checkEq("rst_valid", out_valid, 0);
    checkEq("rst_result", result, 0);
    checkEq("rst_tag", out_tag, 0);
    checkEq("rst_cc", condCodes, 0);
    checkEq("rst_flags", opStatusFlags, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    //   name       a         b         sub   tag   result    {ZCNV}   {OF,UF,NX,NV}
    doOp("one_one", 16'h3C00, 16'h3C00, 1'b0, 4'd3, 16'h4000, 4'b0000, 4'b0000);
    doOp("cancel",  16'h3C00, 16'h3C00, 1'b1, 4'd5, 16'h0000, 4'b1000, 4'b0000);
    doOp("tie_even", 16'h3C00, 16'h1000, 1'b0, 4'd6, 16'h3C00, 4'b0000, 4'b0010);
    doOp("ovf",     16'h7BFF, 16'h7BFF, 1'b0, 4'd7, 16'h7C00, 4'b0001, 4'b1010);
    doOp("inf_inf", 16'h7C00, 16'hFC00, 1'b0, 4'd8, 16'h7E00, 4'b0000, 4'b0001);
    doOp("subn",    16'h0001, 16'h0001, 1'b0, 4'd9, 16'h0002, 4'b0000, 4'b0000);
    doOp("neg_zero", 16'h8000, 16'h8000, 1'b0, 4'd10, 16'h8000, 4'b1010, 4'b0000);
    doOp("snan",    16'h7D00, 16'h3C00, 1'b0, 4'd11, 16'h7E00, 4'b0000, 4'b0001);
    doOp("qnan",    16'h7E00, 16'h3C00, 1'b0, 4'd12, 16'h7E00, 4'b0000, 4'b0000);
    doOp("inf_fin", 16'h7C00, 16'h3C00, 1'b0, 4'd13, 16'h7C00, 4'b0000, 4'b0000);
    doOp("neg_res", 16'h3C00, 16'h4000, 1'b1, 4'd14, 16'hBC00, 4'b0010, 4'b0000);

    // Back-to-back burst with a two-cycle output stall at the first result.
    seen.delete();
    idx       = 0;
    stalled   = 1'b0;
    stallLeft = 0;
    sawFull   = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (idx < 5) begin
        in_valid = 1'b1;
        a        = 16'h3C00;
        b        = burstB[idx];
        sub      = 1'b0;
        in_tag   = 4'(idx);
      end else begin
        in_valid = 1'b0;
      end
      if (!stalled && out_valid) begin
        stalled   = 1'b1;
        stallLeft = 2;
        out_ready = 1'b0;
      end else if (stallLeft > 0) begin
        checkEq("hold_valid", out_valid, 1);
        checkEq("hold_result", result, burstExp[0]);
        checkEq("hold_tag", out_tag, 0);
        stallLeft--;
        if (stallLeft == 0) out_ready = 1'b1;
      end
      @(negedge clock);
      acc = in_valid && in_ready;
      if (!in_ready) sawFull = 1'b1;
      @(posedge clock); #1;
      if (acc) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkEq("burst_stalled", stalled, 1);
    checkEq("burst_full", sawFull, 1);
    checkEq("burst_count", seen.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < seen.size()) begin
        checkEq($sformatf("burst%0d_tag", i), seen[i][19:16], i);
        checkEq($sformatf("burst%0d_res", i), seen[i][15:0], burstExp[i]);
      end
    end

    // Reset with three operations in flight.
    seen.delete();
    for (int i = 0; i < 3; i++) begin
      a        = 16'h3C00;
      b        = 16'h3C00;
      sub      = 1'b0;
      in_tag   = 4'(i + 8);
      in_valid = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    checkEq("pre_rst_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    checkEq("mid_rst_valid", out_valid, 0);
    checkEq("mid_rst_result", result, 0);
    checkEq("mid_rst_tag", out_tag, 0);
    checkEq("mid_rst_cc", condCodes, 0);
    checkEq("mid_rst_flags", opStatusFlags, 0);
    @(posedge clock); #2;
    reset_n = 1'b1;
    #1;
    checkEq("post_rst_ready", in_ready, 1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (out_valid) cnt++;
    end
    checkEq("no_stale_valid", cnt, 0);
    checkEq("no_stale_seen", seen.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_addsub_pipe.md
FPU_ADDSUB_PIPE -- requirements
Module: fpu_addsub_pipe

Interface
REQ-001 SHALL have parameter EXPW, default 5, meaning exponent field width.
REQ-002 SHALL have parameter FRACW, default 10, meaning stored fraction width.
REQ-003 SHALL have parameter TAGW, default 4, meaning width of the opaque tag carried with each operation.
REQ-004 SHALL have port clock, input, 1 bit: single clock, all state on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operation offered.
REQ-007 SHALL have port in_ready, output, 1 bit: operation accepted when in_valid && in_ready.
REQ-008 SHALL have port sub, input, 1 bit: 1 computes a-b, 0 computes a+b.
REQ-009 SHALL have ports a and b, input, EXPW+FRACW+1 bits each: operands packed {sign, exp, frac}.
REQ-010 SHALL have port in_tag, input, TAGW bits: tag carried with the operation.
REQ-011 SHALL have port out_valid, output, 1 bit: result present.
REQ-012 SHALL have port out_ready, input, 1 bit: result consumed when out_valid && out_ready.
REQ-013 SHALL have port result, output, EXPW+FRACW+1 bits: rounded sum.
REQ-014 SHALL have port out_tag, output, TAGW bits: tag of the current result.
REQ-015 SHALL have port condCodes, output, 4 bits: {Z, C, N, V}.
REQ-016 SHALL have port opStatusFlags, output, 4 bits: {OF, UF, NX, NV} (overflow, underflow, inexact, invalid).

Function
REQ-017 SHALL be a 3-stage pipeline (S1 unpack/sort/align, S2 significand add/sub + LZC, S3 normalize/round/pack), latency exactly 3 cycles from accept to out_valid when not stalled.
REQ-018 SHALL sustain one accept per cycle with out_ready held 1.
REQ-019 SHALL advance a stage when it is empty or the next stage advances; in_ready = S1 empty or S1 advancing (combinational, no dependence on in_valid).
REQ-020 SHALL hold result, out_tag, condCodes and opStatusFlags stable while out_valid && !out_ready; no operation is dropped, duplicated or reordered.
REQ-021 SHALL use bias 2^(EXPW-1)-1, implicit leading 1 for exp != 0, and exp = 0 as subnormal with effective exponent 1.
REQ-022 SHALL negate b's sign when sub = 1, order operands by magnitude, and align the smaller with guard, round and sticky bits (sticky = OR of all bits shifted beyond round; shift saturates at FRACW+3).
REQ-023 SHALL round to nearest, ties to even; NX = 1 whenever any discarded bit is nonzero.
REQ-024 SHALL, on exponent overflow after rounding, output signed infinity with OF = 1 and NX = 1.
REQ-025 SHALL set UF = 1 only when the result is subnormal or zero before rounding and NX = 1.
REQ-026 SHALL return +0 for exact cancellation of nonzero operands, and -0 only for (-0)+(-0).
REQ-027 SHALL treat any NaN input as producing canonical quiet NaN {0, all-ones exp, frac MSB 1, rest 0}; NV = 1 if an input NaN has frac MSB 0 or for inf-inf of opposite effective signs.
REQ-028 SHALL propagate infinity for inf + finite and inf + same-sign inf, flags 0.
REQ-029 SHALL set Z = result is +/-0, C = 0, N = result sign bit (0 for NaN), V = OF.
REQ-030 SHALL carry in_tag through the pipeline alongside its operation.

Reset
REQ-031 SHALL, while reset_n = 0, asynchronously clear all stage valid bits, out_valid = 0, result = 0, out_tag = 0, condCodes = 0, opStatusFlags = 0.
REQ-032 SHALL discard in-flight operations on reset mid-operation; in_ready = 1 in the first cycle after reset_n rises.
REQ-033 SHALL leave datapath registers other than outputs unreset if desired; valid bits alone gate visibility.

Verification (defaults EXPW=5, FRACW=10)
REQ-034 SHALL cover a=0x3C00, b=0x3C00, sub=0, tag=3 -> 3 cycles later result 0x4000, out_tag 3, flags 0, condCodes 0.
REQ-035 SHALL cover a=0x3C00, b=0x3C00, sub=1 -> result 0x0000, Z=1; and a=0x3C00, b=0x1000 -> 0x3C00 (tie to even), NX=1.
REQ-036 SHALL cover a=0x7BFF, b=0x7BFF -> 0x7C00, OF=1, NX=1, V=1; a=0x7C00, b=0xFC00 -> 0x7E00, NV=1.
REQ-037 SHALL cover a=0x0001, b=0x0001 -> 0x0002, flags 0 (subnormal path).
REQ-038 SHALL cover 5 back-to-back ops tags 0..4 with out_ready=0 for 2 cycles after first out_valid -> outputs held, in_ready drops when full, all 5 results emerge in tag order.
REQ-039 SHALL cover reset_n pulsed low with 3 ops in flight -> out_valid = 0 immediately, no stale result after release.
